mmio_timer_core: RTL and testbench
==================================

Name: mmio_timer_core

Overview:
Slot-side MMIO timer device that answers the MMIO controller's per-slot handshake: chip select, read/write strobes, 8-bit register address, write data, and done/idle/error returns. It is the responder end of the slot interface and occupies slot 0 (address 0x4600_00xx).
- Registers: control, period, prescaler, live count and sticky status.
- Raises a level interrupt on period match.

Parameters:
PRESC_W, 16, prescaler register width (bits); upper bits of the 32-bit register read as 0
CNT_W, 32, counter and period width; must be ≤ 32

Ports:
aclk  in  1  system clock
arst  in  1  reset, synchronous, active-high
cs  in  1  slot chip select
read  in  1  read strobe; valid only with cs
write  in  1  write strobe; valid only with cs
reg_addr  in  8  register index
wr_data  in  32  write data; valid the cycle AFTER the command-accept edge
rd_data  out  32  read data; held from rd_done until the next accepted command
wr_done  out  1  one-cycle write-complete pulse
rd_done  out  1  one-cycle read-complete pulse
idle  out  1  high when the FSM is in IDLE
slave_error  out  1  error flag for the last accepted command; held until the next accept
decode_error  out  1  unmapped-address flag for the last accepted command; held until the next accept
irq  out  1  STATUS.MATCH & CTRL.IRQ_EN

Behaviour:
- Reset (synchronous, arst=1 at a posedge): all registers, counter and prescaler = 0; rd_data = 0; all done/error flags = 0; irq = 0; FSM = IDLE, so idle = 1.
- Reset overrides any in-flight command; no done pulse is emitted for it.
- Register map (reg_addr):
  - 0x00 CTRL RW: bit0 EN, bit1 CLR (write-only; self-clearing, reads 0), bit2 AUTO_RELOAD, bit3 IRQ_EN.
  - 0x01 PERIOD RW.
  - 0x02 PRESCALE RW.
  - 0x03 COUNT RO.
  - 0x04 STATUS: bit0 MATCH, sticky, write-1-to-clear.
  - Unused bits read 0.
- Error rules:
  - Any other address: decode_error = 1; the write is dropped and the read returns 0.
  - Write to COUNT: slave_error = 1, write dropped.
  - Both error flags are registered at the accept edge, so they are valid in the controller's response cycle.
- FSM states: IDLE, WR_COMMIT, RD_ACK.
  - IDLE: when cs&write, latch reg_addr and go to WR_COMMIT. Otherwise when cs&read, latch rd_data and flags and go to RD_ACK. If write and read are both high, write wins.
  - WR_COMMIT: wr_done = 1 for this cycle. At the exiting edge, sample wr_data and update the target register. Unconditional return to IDLE. cs/read/write are ignored in this state.
  - RD_ACK: rd_done = 1 for this cycle. Unconditional return to IDLE. cs/read/write are ignored here; the controller still holds cs&read this cycle, and that must not retrigger a read.
- Latency:
  - Write: done 1 cycle after the accept edge.
  - Read: rd_done and rd_data 1 cycle after the accept edge; rd_data stays stable while the controller waits for its response handshake.
- Counter:
  - Prescaler: when EN, presc increments and wraps to 0 after reaching PRESCALE. That wrap edge is a tick. PRESCALE = 0 gives a tick every cycle.
  - On a tick, if count == PERIOD: set MATCH. With AUTO_RELOAD, count goes to 0. Without it, count holds and EN clears to 0 (one-shot).
  - On a tick otherwise, count + 1, modulo 2^CNT_W (wraps).
  - EN = 0: count and presc hold.
- Simultaneous events:
  - CLR commit: count = 0 and presc = 0; overrides the tick that edge.
  - Register commit on a tick edge: the tick compare uses the pre-write PERIOD, PRESCALE and EN.
  - STATUS W1C on the same edge as a MATCH set: set wins, MATCH stays 1.
  - CTRL write clearing EN on a tick edge: the tick applies, and EN = 0 after that edge.
- irq is combinational from registered bits; no glitch path from bus inputs.

Test Plan:
1. Reset, then read 0x00–0x04 -> rd_done pulses 1 cycle after each accept; all data = 0; idle = 1 between reads; no errors.
2. Write PERIOD = 3, PRESCALE = 0, CTRL = 0x0D (EN, AUTO_RELOAD, IRQ_EN) -> COUNT sequence 1,2,3,0,1…; MATCH and irq rise on the 3→0 edge; write STATUS = 1 -> irq = 0.
3. One-shot: PERIOD = 2, PRESCALE = 1, CTRL = 0x01 -> count advances every 2 cycles to 2, then holds at 2; EN reads 0; MATCH = 1.
4. Write 0x03 -> slave_error = 1, COUNT unchanged. Read 0x7F -> decode_error = 1, rd_data = 0. The next valid read clears both flags.
5. Hold cs&read high for 2 cycles -> exactly one rd_done pulse. Assert cs&write&read together -> treated as a write only.
6. Assert arst while in WR_COMMIT -> no wr_done pulse; register unchanged (0); idle = 1 the next cycle. STATUS W1C on the same edge as a match -> MATCH stays 1.

Source files
------------

// File: rtl/mmio_timer_core.sv
// mmio_timer_core: slot-0 MMIO responder with a prescaled period timer.
// Registers: CTRL(0x00) PERIOD(0x01) PRESCALE(0x02) COUNT(0x03, RO) STATUS(0x04, W1C).
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for cs&write or cs&read; idle = 1
// S_WR_COMMIT | wr_done pulse; wr_data sampled and committed at exit edge
// S_RD_ACK    | rd_done pulse; rd_data already latched; bus inputs ignored
module mmio_timer_core #(
  parameter int PRESC_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        wr_done,
  output logic        rd_done,
  output logic        idle,
  output logic        slave_error,
  output logic        decode_error,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_COMMIT,
    S_RD_ACK
  } state_t;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PERIOD = 8'h01;
  localparam logic [7:0] A_PRESC  = 8'h02;
  localparam logic [7:0] A_COUNT  = 8'h03;
  localparam logic [7:0] A_STATUS = 8'h04;

  state_t             state, state_nxt;
  logic [7:0]         wr_addr;
  logic               ctrl_en, ctrl_auto, ctrl_irq_en;
  logic               sts_match;
  logic [CNT_W-1:0]   period, count;
  logic [PRESC_W-1:0] prescale, presc;

  logic               accept_wr, accept_rd, commit, wr_ok;
  logic               wr_ctrl, wr_period, wr_presc, wr_sts, clr_cmd;
  logic               addr_bad, tick, match_hit;
  logic [31:0]        rd_mux;

  // Next-state logic; a write request wins over a simultaneous read
  always_comb begin
    state_nxt = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state)
      S_IDLE: begin
        if (cs && write) begin
          accept_wr = 1'b1;
          state_nxt = S_WR_COMMIT;
        end else if (cs && read) begin
          accept_rd = 1'b1;
          state_nxt = S_RD_ACK;
        end
      end
      S_WR_COMMIT: state_nxt = S_IDLE;
      S_RD_ACK:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge aclk) begin
    if (arst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Done pulses are suppressed in a reset cycle so an aborted command never completes
  assign commit  = (state == S_WR_COMMIT);
  assign wr_done = commit && !arst;
  assign rd_done = (state == S_RD_ACK) && !arst;
  assign idle    = (state == S_IDLE);
  assign irq     = sts_match && ctrl_irq_en;

  // Read mux and address decode, evaluated against the live register values
  always_comb begin
    addr_bad = (reg_addr > A_STATUS);
    rd_mux   = 32'd0;
    case (reg_addr)
      A_CTRL:   rd_mux = {28'd0, ctrl_irq_en, ctrl_auto, 1'b0, ctrl_en};
      A_PERIOD: rd_mux = 32'(period);
      A_PRESC:  rd_mux = 32'(prescale);
      A_COUNT:  rd_mux = 32'(count);
      A_STATUS: rd_mux = {31'd0, sts_match};
      default:  rd_mux = 32'd0;
    endcase
  end

  // Command capture at the accept edge: address, response flags and read data
  always_ff @(posedge aclk) begin
    if (arst) begin
      wr_addr      <= 8'd0;
      rd_data      <= 32'd0;
      slave_error  <= 1'b0;
      decode_error <= 1'b0;
    end else if (accept_wr) begin
      wr_addr      <= reg_addr;
      decode_error <= addr_bad;
      slave_error  <= (reg_addr == A_COUNT);
    end else if (accept_rd) begin
      rd_data      <= rd_mux;
      decode_error <= addr_bad;
      slave_error  <= 1'b0;
    end
  end

  // Flags latched at accept tell the commit edge whether the write is dropped
  assign wr_ok     = commit && !slave_error && !decode_error;
  assign wr_ctrl   = wr_ok && (wr_addr == A_CTRL);
  assign wr_period = wr_ok && (wr_addr == A_PERIOD);
  assign wr_presc  = wr_ok && (wr_addr == A_PRESC);
  assign wr_sts    = wr_ok && (wr_addr == A_STATUS);
  assign clr_cmd   = wr_ctrl && wr_data[1];

  // A CLR commit cancels the whole tick on that edge, including the match
  assign tick      = ctrl_en && (presc == prescale);
  assign match_hit = tick && (count == period) && !clr_cmd;

  // CTRL bits; a bus write overrides the one-shot EN clear on the same edge
  always_ff @(posedge aclk) begin
    if (arst) begin
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en     <= wr_data[0];
      ctrl_auto   <= wr_data[2];
      ctrl_irq_en <= wr_data[3];
    end else if (match_hit && !ctrl_auto) begin
      ctrl_en     <= 1'b0;
    end
  end

  // PERIOD and PRESCALE registers
  always_ff @(posedge aclk) begin
    if (arst) begin
      period   <= '0;
      prescale <= '0;
    end else begin
      if (wr_period) period   <= wr_data[CNT_W-1:0];
      if (wr_presc)  prescale <= wr_data[PRESC_W-1:0];
    end
  end

  // Prescaler and counter; both hold while EN is low
  always_ff @(posedge aclk) begin
    if (arst) begin
      presc <= '0;
      count <= '0;
    end else if (clr_cmd) begin
      presc <= '0;
      count <= '0;
    end else if (ctrl_en) begin
      if (tick) begin
        presc <= '0;
        if (count == period) begin
          if (ctrl_auto) count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Sticky MATCH; a new match beats a simultaneous write-1-to-clear
  always_ff @(posedge aclk) begin
    if (arst)                        sts_match <= 1'b0;
    else if (match_hit)              sts_match <= 1'b1;
    else if (wr_sts && wr_data[0])   sts_match <= 1'b0;
  end

endmodule

// File: tb/tb_mmio_timer_core.sv
// Self-checking bench for mmio_timer_core: directed scenarios plus random
// traffic, scored against a behavioural timer/register model.
module tb_mmio_timer_core;

  logic        aclk = 1'b0;
  logic        arst, cs, read, write;
  logic [7:0]  reg_addr;
  logic [31:0] wr_data, rd_data;
  logic        wr_done, rd_done, idle, slave_error, decode_error, irq;

  always #5 aclk = ~aclk;

  mmio_timer_core #(.PRESC_W(16), .CNT_W(32)) dut (
    .aclk(aclk), .arst(arst), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
    .wr_done(wr_done), .rd_done(rd_done), .idle(idle),
    .slave_error(slave_error), .decode_error(decode_error), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit [31:0] data;
    bit        derr;
    bit        serr;
  } exp_t;

  exp_t rq[$];
  exp_t wq[$];

  bit [31:0] m_period, m_count;
  int        m_presc, m_prescale;
  bit        m_en, m_auto, m_ien, m_match;
  bit [7:0]  m_pend_addr;

  // requests posted by the driver for the coming edge
  bit        r_req, wa_req, wc_req;
  bit [7:0]  r_addr, a_addr;
  bit [31:0] c_data;
  bit [31:0] last_rd;

  function automatic bit [31:0] model_read(input bit [7:0] a);
    case (a)
      8'h00:   return {28'd0, m_ien, m_auto, 1'b0, m_en};
      8'h01:   return m_period;
      8'h02:   return 32'(m_prescale);
      8'h03:   return m_count;
      8'h04:   return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge aclk) begin
    bit tick, mset, clr;
    exp_t e;
    if (arst) begin
      m_period = 0; m_count = 0; m_presc = 0; m_prescale = 0;
      m_en = 0; m_auto = 0; m_ien = 0; m_match = 0; m_pend_addr = 0;
      rq.delete(); wq.delete();
    end else begin
      if (r_req) begin
        e.data = model_read(r_addr); e.derr = (r_addr > 8'h04); e.serr = 1'b0;
        rq.push_back(e);
      end
      if (wa_req) begin
        e.data = 0; e.derr = (a_addr > 8'h04); e.serr = (a_addr == 8'h03);
        wq.push_back(e);
        m_pend_addr = a_addr;
      end
      clr  = wc_req && (m_pend_addr == 8'h00) && c_data[1];
      tick = m_en && (m_presc == m_prescale);
      mset = 0;
      if (clr) begin
        m_count = 0; m_presc = 0;
      end else if (m_en) begin
        m_presc = tick ? 0 : (m_presc + 1) % 65536;
        if (tick) begin
          if (m_count == m_period) begin
            mset = 1;
            if (m_auto) m_count = 0; else m_en = 0;
          end else begin
            m_count = m_count + 1;
          end
        end
      end
      if (wc_req) begin
        case (m_pend_addr)
          8'h00: begin m_en = c_data[0]; m_auto = c_data[2]; m_ien = c_data[3]; end
          8'h01: m_period = c_data;
          8'h02: m_prescale = int'(c_data & 32'h0000_FFFF);
          8'h04: if (c_data[0]) m_match = 0;
          default: ;
        endcase
      end
      if (mset) m_match = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge aclk) begin
    exp_t e;
    check("irq", 32'(irq), 32'(m_match & m_ien));
    if (rd_done) begin
      if (rq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_done_unexpected: got rd_done=1, expected no pulse at %0t", $time);
      end else begin
        e = rq.pop_front();
        last_rd = e.data;
        check("rd_data", rd_data, e.data);
        check("rd_decode_error", 32'(decode_error), 32'(e.derr));
        check("rd_slave_error", 32'(slave_error), 32'(e.serr));
      end
    end
    if (wr_done) begin
      if (wq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_done_unexpected: got wr_done=1, expected no pulse at %0t", $time);
      end else begin
        e = wq.pop_front();
        check("wr_decode_error", 32'(decode_error), 32'(e.derr));
        check("wr_slave_error", 32'(slave_error), 32'(e.serr));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic gap(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic do_write(input bit [7:0] a, input bit [31:0] d, input bit with_read, input bit hold);
    cs = 1; write = 1; read = with_read; reg_addr = a;
    wa_req = 1; a_addr = a;
    @(negedge aclk);
    check("idle_in_write", 32'(idle), 32'd0);
    cs = hold; write = hold; read = hold & with_read; reg_addr = 8'($urandom);
    wa_req = 0;
    wr_data = d; wc_req = 1; c_data = d;
    @(negedge aclk);
    cs = 0; write = 0; read = 0;
    wc_req = 0; wr_data = $urandom;
  endtask

  task automatic do_read(input bit [7:0] a);
    cs = 1; read = 1; write = 0; reg_addr = a;
    r_req = 1; r_addr = a;
    @(negedge aclk);
    r_req = 0;
    check("idle_in_read", 32'(idle), 32'd0);
    @(negedge aclk);
    cs = 0; read = 0;
    check("idle_after_read", 32'(idle), 32'd1);
    check("rd_data_held", rd_data, last_rd);
  endtask

  task automatic do_reset();
    arst = 1; r_req = 0; wa_req = 0; wc_req = 0;
    cs = 0; read = 0; write = 0;
    @(negedge aclk);
    arst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [7:0]  a;
    bit [31:0] d;
    arst = 1; cs = 0; read = 0; write = 0; reg_addr = 0; wr_data = 0;
    r_req = 0; wa_req = 0; wc_req = 0; r_addr = 0; a_addr = 0; c_data = 0; last_rd = 0;
    @(negedge aclk);
    do_reset();
    check("reset_idle", 32'(idle), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);

    // reset values of every register
    for (int i = 0; i < 5; i++) do_read(8'(i));

    // auto-reload period 3 with irq
    do_write(8'h01, 32'd3, 0, 0);
    do_write(8'h02, 32'd0, 0, 0);
    do_write(8'h00, 32'h0D, 0, 0);
    for (int i = 0; i < 6; i++) do_read(8'h03);
    do_read(8'h04);
    do_write(8'h04, 32'd1, 0, 0);
    do_write(8'h00, 32'h00, 0, 0);
    do_write(8'h04, 32'd1, 0, 0);
    check("irq_after_w1c", 32'(irq), 32'd0);

    // one-shot
    do_write(8'h00, 32'h02, 0, 0);
    do_write(8'h01, 32'd2, 0, 0);
    do_write(8'h02, 32'd1, 0, 0);
    do_write(8'h00, 32'h01, 0, 0);
    gap(12);
    do_read(8'h03);
    check("oneshot_count", last_rd, 32'd2);
    do_read(8'h00);
    check("oneshot_en", last_rd, 32'd0);
    do_read(8'h04);
    check("oneshot_match", last_rd, 32'd1);

    // error responses
    do_write(8'h03, 32'h55, 0, 0);
    do_read(8'h03);
    do_read(8'h7F);
    do_write(8'h9A, 32'h1234, 0, 0);
    do_read(8'h01);

    // write and read together, with bus held through the commit cycle
    do_write(8'h01, 32'd7, 1, 1);
    do_read(8'h01);

    // reset during WR_COMMIT
    cs = 1; write = 1; reg_addr = 8'h01; wa_req = 1; a_addr = 8'h01;
    @(negedge aclk);
    cs = 0; write = 0; wa_req = 0; wr_data = 32'd9;
    do_reset();
    check("idle_after_abort", 32'(idle), 32'd1);
    do_read(8'h01);
    check("period_after_abort", last_rd, 32'd0);

    // W1C racing a match every cycle
    do_write(8'h00, 32'h0D, 0, 0);
    gap(2);
    do_write(8'h04, 32'd1, 0, 0);
    do_read(8'h04);
    check("w1c_vs_match", last_rd, 32'd1);
    do_write(8'h00, 32'h02, 0, 0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: a = 8'h00; 1: a = 8'h01; 2: a = 8'h02; 3: a = 8'h03;
        4: a = 8'h04; 5: a = 8'h05; 6: a = 8'h7F; default: a = 8'($urandom);
      endcase
      case (a)
        8'h00:   d = $urandom & 32'hF;
        8'h01:   d = $urandom_range(0, 6);
        8'h02:   d = $urandom_range(0, 2);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) do_write(a, d, 1'($urandom), 1'($urandom));
      else                           do_read(a);
      gap($urandom_range(0, 3));
    end

    gap(3);
    check("rq_drained", 32'(rq.size()), 32'd0);
    check("wq_drained", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
